store_align_unit: RTL and testbench
===================================

Name: store_align_unit

Overview:
- Store-side counterpart of the datapath's load/immediate extension logic: narrows and lane-aligns 32-bit register data onto a 32-bit word-addressed, byte-enabled data-memory write port.
- Sits between the EX/MEM store path and data memory.
- Accepts one store request (byte/half/word, any byte address).
- Emits one aligned memory write, or two for misaligned accesses that cross a word boundary.
- Reports completion or error.

Parameters:
- ADDR_W, 32, address width in bits; wrap arithmetic is modulo 2^ADDR_W.
- ALLOW_MISALIGNED, 1:
  - 1 = split word-crossing stores into two beats.
  - 0 = reject them with err and no bus activity.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- st_valid  input  1  store request valid
- st_ready  output  1  unit can accept a request this cycle
- st_addr  input  ADDR_W  byte address of store
- st_data  input  32  register data; value in LSBs
- st_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- mem_req  output  1  memory write request
- mem_ack  input  1  memory accepted current beat
- mem_addr  output  ADDR_W  word-aligned address (bits [1:0] = 0)
- mem_wdata  output  32  lane-aligned write data
- mem_be  output  4  byte enables, bit i = lane i = bits [8i+7:8i]
- done  output  1  one-cycle pulse: store fully written
- err  output  1  one-cycle pulse: request rejected

Behaviour:
- Reset:
  - One clock; rst is asynchronous and active-high.
  - On rst, state goes to IDLE and all outputs are driven to their reset values:
    - mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0
    - done=0, err=0, st_ready=0
  - st_ready=0 while rst is high and rises the first cycle after release.
  - Reset mid-transaction drops mem_req immediately and abandons the store; no done is issued.
- Byte ordering: little-endian. off = st_addr[1:0]; nbytes = 1, 2 or 4.
- Lane computation (at accept):
  - Mask st_data to nbytes.
  - 64-bit wide_data = masked data << (8*off).
  - 8-bit wide_be = ((1<<nbytes)-1) << off.
  - Beat0 = low halves; beat1 = high halves.
  - split = |wide_be[7:4]:
    - byte: never split.
    - half: split only when off=3.
    - word: split when off≠0.
  - Unused lanes drive 0 in mem_wdata.
- Addresses:
  - beat0 mem_addr = st_addr with [1:0] cleared.
  - beat1 mem_addr = beat0 + 4, modulo 2^ADDR_W (0xFFFFFFFC wraps to 0x00000000).
- FSM states: IDLE, BEAT0, BEAT1.
  - IDLE:
    - st_ready=1.
    - Accept on st_valid && st_ready; latch the computed beats.
    - st_size=11, or (split && ALLOW_MISALIGNED=0): stay in IDLE, pulse err next cycle, no mem_req.
    - Otherwise go to BEAT0.
  - BEAT0:
    - mem_req=1; addr/wdata/be held stable until mem_ack is sampled high.
    - On ack: if split, go to BEAT1; else go to IDLE with done=1 next cycle.
  - BEAT1: same rules as BEAT0; on ack go to IDLE with done=1.
- Timing and handshake:
  - st_ready=0 in BEAT0/BEAT1.
  - Minimum latency with mem_ack tied high:
    - non-split: accept at cycle N, req at N+1, done at N+2.
    - split: done at N+3.
  - done/err are asserted in the same cycle st_ready returns to 1. A new request is accepted in that cycle, back-to-back.
  - mem_ack while mem_req=0 is ignored.
  - mem_addr/wdata/be return to 0 in IDLE.
  - Inputs are sampled only at the accept edge; later changes on st_* have no effect.

Decomposition:
- Shared package (store_pkg):
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD.
  - FSM state enum.
  - Lane-width constant (4).
- One natural combinational sub-module, lane_shifter: size/off/data to 64-bit wide_data and 8-bit wide_be.
- FSM and output registers live in the top module.

Test Plan:
- Word store, addr 0x10000000, data 0xAABBCCDD, ack tied high -> one beat: addr 0x10000000, wdata 0xAABBCCDD, be 1111; done 2 cycles after accept.
- Byte store, addr 0x10000001, data 0xFFFFFF9A -> one beat: addr 0x10000000, wdata 0x00009A00, be 0010.
- Word store, addr 0x10000002, data 0xAABBCCDD ->
  - beat0: 0x10000000 / 0xCCDD0000 / 1100.
  - beat1: 0x10000004 / 0x0000AABB / 0011.
  - done 3 cycles after accept.
- Half store, addr 0xFFFFFFFF, data 0x12345678 ->
  - beat0: 0xFFFFFFFC / 0x78000000 / 1000.
  - beat1 (wrap): 0x00000000 / 0x00000056 / 0001.
- st_size=11, and (with ALLOW_MISALIGNED=0) a word store at 0x...1 -> err pulse 1 cycle after accept, mem_req never asserts, st_ready stays 1.
- mem_ack held low 5 cycles during beat0, then rst asserted -> beat0 outputs stable throughout; mem_req=0 immediately on rst; no done; st_ready=1 the first cycle after rst release.

Source files
------------

// File: rtl/store_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
// Shared definitions for the store alignment unit:
//   - size_e  : store size encodings carried on st_size
//   - state_e : FSM states of the store sequencer
//   - LANES   : byte lanes per memory word
// -----------------------------------------------------------------------------
package store_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_BEAT0 = 2'b01,
    S_BEAT1 = 2'b10
  } state_e;

endpackage

// File: rtl/store_align_unit_if.sv
// -----------------------------------------------------------------------------
// store_align_unit_if
// Bundles the store-request side and the data-memory write side of the
// store alignment unit.
//   st_valid/st_ready/st_addr/st_data/st_size : store request handshake
//   mem_req/mem_ack/mem_addr/mem_wdata/mem_be : memory write beat handshake
//   done/err                                  : completion / rejection pulses
// Modports:
//   slave  : the alignment unit itself
//   master : the environment (pipeline + memory) around it
// -----------------------------------------------------------------------------
interface store_align_unit_if #(
  parameter int ADDR_W = 32
) ();

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_size;
  logic              mem_req;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              done;
  logic              err;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ack,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_be, done, err
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ack,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_be, done, err
  );

endinterface

// File: rtl/lane_shifter.sv
// -----------------------------------------------------------------------------
// lane_shifter
// Combinational lane placement for a store: masks register data to the store
// size and shifts data and byte enables up by the byte offset into a two-word
// (64-bit / 8-lane) window. The low word is beat0, the high word beat1.
//   size_i      : store size encoding (store_pkg::size_e)
//   off_i       : byte offset within the word (address bits [1:0])
//   data_i      : register data, value in the LSBs
//   wide_data_o : lane-aligned data over two words, unused lanes zero
//   wide_be_o   : byte enables over two words
// -----------------------------------------------------------------------------
module lane_shifter
  import store_pkg::*;
(
  input  logic [1:0]           size_i,
  input  logic [1:0]           off_i,
  input  logic [31:0]          data_i,
  output logic [2*LANES*8-1:0] wide_data_o,
  output logic [2*LANES-1:0]   wide_be_o
);

  logic [LANES-1:0]   be_base;
  logic [LANES*8-1:0] masked;

  // Each lane keeps its byte only when its enable is set, so a reserved
  // size (no enables) yields all-zero data as well.
  always_comb begin
    case (size_e'(size_i))
      SZ_BYTE: be_base = 4'b0001;
      SZ_HALF: be_base = 4'b0011;
      SZ_WORD: be_base = 4'b1111;
      default: be_base = 4'b0000;
    endcase
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
      assign masked[8*gi +: 8] = be_base[gi] ? data_i[8*gi +: 8] : 8'h00;
    end
  endgenerate

  assign wide_data_o = {32'h0, masked} << {off_i, 3'b000};
  assign wide_be_o   = {4'h0, be_base} << off_i;

endmodule

// File: rtl/store_align_unit.sv
// -----------------------------------------------------------------------------
// store_align_unit
// Narrows and lane-aligns a 32-bit store onto a word-addressed, byte-enabled
// memory write port. Stores that cross a word boundary are issued as two
// beats (or rejected when ALLOW_MISALIGNED=0). All outputs are registered.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : store_align_unit_if.slave (request in, memory beats out,
//         done/err pulses)
// -----------------------------------------------------------------------------
module store_align_unit
  import store_pkg::*;
#(
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  store_align_unit_if.slave  bus
);

  state_e            state_q,     state_d;
  logic              st_ready_q,  st_ready_d;
  logic              mem_req_q,   mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q,    mem_be_d;
  logic              done_q,      done_d;
  logic              err_q,       err_d;
  // Second beat captured at accept so st_* may change afterwards.
  logic [ADDR_W-1:0] b1_addr_q,   b1_addr_d;
  logic [31:0]       b1_wdata_q,  b1_wdata_d;
  logic [3:0]        b1_be_q,     b1_be_d;
  logic              split_q,     split_d;

  logic [63:0]       wide_data;
  logic [7:0]        wide_be;
  logic              split_now;
  logic              accept;
  logic              reject;
  logic [ADDR_W-1:0] base_addr;

  lane_shifter u_lane_shifter (
    .size_i      (bus.st_size),
    .off_i       (bus.st_addr[1:0]),
    .data_i      (bus.st_data),
    .wide_data_o (wide_data),
    .wide_be_o   (wide_be)
  );

  assign split_now = |wide_be[7:4];
  assign base_addr = {bus.st_addr[ADDR_W-1:2], 2'b00};
  // st_ready_q is only ever high in IDLE, so this is the IDLE accept.
  assign accept    = bus.st_valid && st_ready_q;
  assign reject    = (size_e'(bus.st_size) == SZ_RSVD) ||
                     (split_now && !ALLOW_MISALIGNED);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    b1_addr_d   = b1_addr_q;
    b1_wdata_d  = b1_wdata_q;
    b1_be_d     = b1_be_q;
    split_d     = split_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d     = S_BEAT0;
            mem_req_d   = 1'b1;
            mem_addr_d  = base_addr;
            mem_wdata_d = wide_data[31:0];
            mem_be_d    = wide_be[3:0];
            // Wraps naturally modulo 2^ADDR_W.
            b1_addr_d   = base_addr + ADDR_W'(4);
            b1_wdata_d  = wide_data[63:32];
            b1_be_d     = wide_be[7:4];
            split_d     = split_now;
          end
        end
      end
      S_BEAT0: begin
        if (bus.mem_ack) begin
          if (split_q) begin
            state_d     = S_BEAT1;
            mem_addr_d  = b1_addr_q;
            mem_wdata_d = b1_wdata_q;
            mem_be_d    = b1_be_q;
          end else begin
            state_d     = S_IDLE;
            mem_req_d   = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            mem_be_d    = '0;
            done_d      = 1'b1;
          end
        end
      end
      S_BEAT1: begin
        if (bus.mem_ack) begin
          state_d     = S_IDLE;
          mem_req_d   = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_be_d    = '0;
          done_d      = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        mem_req_d   = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_be_d    = '0;
      end
    endcase

    // Registered so it stays low through reset and rises one cycle after.
    st_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      st_ready_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      b1_addr_q   <= '0;
      b1_wdata_q  <= '0;
      b1_be_q     <= '0;
      split_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_ready_q  <= st_ready_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      done_q      <= done_d;
      err_q       <= err_d;
      b1_addr_q   <= b1_addr_d;
      b1_wdata_q  <= b1_wdata_d;
      b1_be_q     <= b1_be_d;
      split_q     <= split_d;
    end
  end

  assign bus.st_ready  = st_ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_store_align_unit.sv
// -----------------------------------------------------------------------------
// tb_store_align_unit
// Directed bench for store_align_unit: one instance with misaligned splitting
// enabled and one with it disabled. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_store_align_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  store_align_unit_if #(.ADDR_W(32)) bus ();
  store_align_unit_if #(.ADDR_W(32)) nm_bus ();

  store_align_unit #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  store_align_unit #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_nm (
    .clk (clk),
    .rst (rst),
    .bus (nm_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    check({tag, ".req"},   {63'b0, bus.mem_req}, 64'd1);
    check({tag, ".addr"},  {32'b0, bus.mem_addr}, {32'b0, a});
    check({tag, ".wdata"}, {32'b0, bus.mem_wdata}, {32'b0, d});
    check({tag, ".be"},    {60'b0, bus.mem_be}, {60'b0, be});
    check({tag, ".ready"}, {63'b0, bus.st_ready}, 64'd0);
    $display("beat %s addr=%h wdata=%h be=%b", tag, bus.mem_addr, bus.mem_wdata, bus.mem_be);
  endtask

  task automatic idle_done(input string tag, input logic exp_done);
    check({tag, ".done"},  {63'b0, bus.done}, {63'b0, exp_done});
    check({tag, ".req0"},  {63'b0, bus.mem_req}, 64'd0);
    check({tag, ".addr0"}, {32'b0, bus.mem_addr}, 64'd0);
    check({tag, ".wd0"},   {32'b0, bus.mem_wdata}, 64'd0);
    check({tag, ".be0"},   {60'b0, bus.mem_be}, 64'd0);
    check({tag, ".rdy1"},  {63'b0, bus.st_ready}, 64'd1);
  endtask

  // Present a request for one cycle; it is accepted at the following edge.
  // st_data is scrambled afterwards to show it is sampled only at accept.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_size  = sz;
    tick();
    bus.st_valid = 1'b0;
    bus.st_data  = 32'hDEADBEEF;
    bus.st_addr  = 32'h55555557;
    bus.st_size  = 2'b10;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.st_valid = 1'b0;  bus.st_addr = '0;  bus.st_data = '0;
    bus.st_size  = 2'b00; bus.mem_ack = 1'b1;
    nm_bus.st_valid = 1'b0;  nm_bus.st_addr = '0;  nm_bus.st_data = '0;
    nm_bus.st_size  = 2'b00; nm_bus.mem_ack = 1'b1;

    // Reset state
    tick();
    check("rst.ready", {63'b0, bus.st_ready}, 64'd0);
    check("rst.req",   {63'b0, bus.mem_req}, 64'd0);
    check("rst.addr",  {32'b0, bus.mem_addr}, 64'd0);
    check("rst.wdata", {32'b0, bus.mem_wdata}, 64'd0);
    check("rst.be",    {60'b0, bus.mem_be}, 64'd0);
    check("rst.done",  {63'b0, bus.done}, 64'd0);
    check("rst.err",   {63'b0, bus.err}, 64'd0);
    rst = 1'b0;
    check("rel.ready0", {63'b0, bus.st_ready}, 64'd0);
    tick();
    check("rel.ready1", {63'b0, bus.st_ready}, 64'd1);
    $display("reset released st_ready=%b", bus.st_ready);

    // Aligned word: done 2 cycles after accept
    issue(32'h10000000, 32'hAABBCCDD, 2'b10);
    beat("w0", 32'h10000000, 32'hAABBCCDD, 4'b1111);
    tick();
    idle_done("w0", 1'b1);

    // Byte at offset 1; issued while st_ready is high but nothing pending
    issue(32'h10000001, 32'hFFFFFF9A, 2'b00);
    beat("b1", 32'h10000000, 32'h00009A00, 4'b0010);
    tick();
    idle_done("b1", 1'b1);

    // Back-to-back: accepted in the done cycle. Split word, done at N+3.
    issue(32'h10000002, 32'hAABBCCDD, 2'b10);
    check("w2.done_clr", {63'b0, bus.done}, 64'd0);
    beat("w2.b0", 32'h10000000, 32'hCCDD0000, 4'b1100);
    tick();
    beat("w2.b1", 32'h10000004, 32'h0000AABB, 4'b0011);
    check("w2.nodone", {63'b0, bus.done}, 64'd0);
    tick();
    idle_done("w2", 1'b1);

    // Half at 0xFFFFFFFF: second beat wraps to address 0
    issue(32'hFFFFFFFF, 32'h12345678, 2'b01);
    beat("h3.b0", 32'hFFFFFFFC, 32'h78000000, 4'b1000);
    tick();
    beat("h3.b1", 32'h00000000, 32'h00000056, 4'b0001);
    tick();
    idle_done("h3", 1'b1);
    tick();
    check("h3.done_pulse", {63'b0, bus.done}, 64'd0);

    // Reserved size: err pulse, no bus activity, stays ready
    issue(32'h00000020, 32'h01020304, 2'b11);
    check("rsv.err",  {63'b0, bus.err}, 64'd1);
    idle_done("rsv", 1'b0);
    $display("reserved size err=%b mem_req=%b", bus.err, bus.mem_req);
    tick();
    check("rsv.err_pulse", {63'b0, bus.err}, 64'd0);
    check("rsv.req",       {63'b0, bus.mem_req}, 64'd0);

    // Misaligned word with splitting disabled
    nm_bus.st_valid = 1'b1;
    nm_bus.st_addr  = 32'h10000001;
    nm_bus.st_data  = 32'hCAFEF00D;
    nm_bus.st_size  = 2'b10;
    tick();
    nm_bus.st_valid = 1'b0;
    check("nm.err",   {63'b0, nm_bus.err}, 64'd1);
    check("nm.req",   {63'b0, nm_bus.mem_req}, 64'd0);
    check("nm.ready", {63'b0, nm_bus.st_ready}, 64'd1);
    check("nm.be",    {60'b0, nm_bus.mem_be}, 64'd0);
    $display("no-misalign word err=%b mem_req=%b", nm_bus.err, nm_bus.mem_req);
    tick();
    check("nm.err_pulse", {63'b0, nm_bus.err}, 64'd0);
    check("nm.req2",      {63'b0, nm_bus.mem_req}, 64'd0);

    // Aligned word with splitting disabled still goes through
    nm_bus.st_valid = 1'b1;
    nm_bus.st_addr  = 32'h00000044;
    nm_bus.st_size  = 2'b10;
    tick();
    nm_bus.st_valid = 1'b0;
    check("nm.ok.req",  {63'b0, nm_bus.mem_req}, 64'd1);
    check("nm.ok.addr", {32'b0, nm_bus.mem_addr}, 64'h44);
    check("nm.ok.err",  {63'b0, nm_bus.err}, 64'd0);
    tick();
    check("nm.ok.done", {63'b0, nm_bus.done}, 64'd1);

    // Stall beat0 for 5 cycles, then reset mid-transaction
    bus.mem_ack = 1'b0;
    issue(32'h00000030, 32'h11223344, 2'b10);
    for (int i = 0; i < 5; i++) begin
      bus.st_data = 32'h0BAD0000 + 32'(i);
      beat($sformatf("stall%0d", i), 32'h00000030, 32'h11223344, 4'b1111);
      tick();
    end
    check("stall.hold", {63'b0, bus.mem_req}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst.req",   {63'b0, bus.mem_req}, 64'd0);
    check("arst.addr",  {32'b0, bus.mem_addr}, 64'd0);
    check("arst.ready", {63'b0, bus.st_ready}, 64'd0);
    check("arst.done",  {63'b0, bus.done}, 64'd0);
    bus.mem_ack = 1'b1;
    tick();
    rst = 1'b0;
    check("arst.ready_low", {63'b0, bus.st_ready}, 64'd0);
    tick();
    check("arst.ready_rise", {63'b0, bus.st_ready}, 64'd1);
    check("arst.nodone",     {63'b0, bus.done}, 64'd0);
    check("arst.noreq",      {63'b0, bus.mem_req}, 64'd0);
    $display("after mid-store reset st_ready=%b done=%b", bus.st_ready, bus.done);
    tick();
    check("arst.nodone2", {63'b0, bus.done}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
